// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_ctrl_pkg
// Purpose : Shared types and constants for the program-counter stage.
//           - pc_state_e : controller state encoding (2 bits)
//           - InstrBytes : byte size of one instruction
//           - AlignMask  : low PC bits that must be zero for a legal target
// Rev     : 1.0  initial release
// ============================================================================
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } pc_state_e;

    localparam int unsigned InstrBytes = 4;
    localparam logic [1:0]  AlignMask  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_ctrl
// Purpose : Program-counter stage feeding the instruction fetch unit. Holds
//           the architectural PC, computes the next fetch address each cycle,
//           freezes while a load/store waits on memory and halts on a
//           misaligned control-flow target.
// Ports   : clk_i, rst_i (async, active-high)
//           instr_valid_i, jump_i, target_i, mem_op_i, mem_done_i  (inputs)
//           pc_o, pc_plus_o, pc_next_o, retire_o, stall_o, halted_o (outputs)
//           cycle_o, instret_o (only with PC_CTRL_PERF_COUNTERS_EN)
// Config  : `define PC_CTRL_PERF_COUNTERS_EN adds 64-bit cycle/instret counters
// Rev     : 1.0  initial release
// ============================================================================
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 32,
    parameter int unsigned          InstrWidth   = 32,
    parameter logic [AddrWidth-1:0] StartAddress = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    input  logic                 jump_i,
    input  logic [AddrWidth-1:0] target_i,
    input  logic                 mem_op_i,
    input  logic                 mem_done_i,
    output logic [AddrWidth-1:0] pc_o,
    output logic [AddrWidth-1:0] pc_plus_o,
    output logic [AddrWidth-1:0] pc_next_o,
    output logic                 retire_o,
    output logic                 stall_o,
    output logic                 halted_o
`ifdef PC_CTRL_PERF_COUNTERS_EN
    ,
    output logic [63:0]          cycle_o,
    output logic [63:0]          instret_o
`endif
);

    localparam logic [AddrWidth-1:0] c_incr = AddrWidth'(InstrWidth / 8);

    pc_state_e            r_state;
    pc_state_e            w_state_next;
    logic [AddrWidth-1:0] r_pc;
    logic [AddrWidth-1:0] w_pc_plus;
    logic [AddrWidth-1:0] w_pc_next;
    logic                 w_retire;
    logic                 w_eval;
    logic                 w_aligned;

    assign w_pc_plus = r_pc + c_incr;
    assign w_aligned = (target_i[1:0] & AlignMask) == 2'b00;

    // BOOT evaluates the first valid instruction exactly as RUN would, so the
    // first fetch is not lost to a dead cycle.
    assign w_eval = instr_valid_i && ((r_state == RUN) || (r_state == BOOT));

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_retire     = 1'b0;
        if (r_state == BOOT) begin
            w_pc_next = StartAddress;
        end
        if (w_eval) begin
            w_state_next = RUN;
            // mem_op_i outranks jump_i: a load/store is never also a jump
            if (mem_op_i) begin
                if (mem_done_i) begin
                    w_pc_next = w_pc_plus;
                    w_retire  = 1'b1;
                end else begin
                    w_pc_next    = r_pc;
                    w_state_next = MEM_WAIT;
                end
            end else if (jump_i) begin
                if (w_aligned) begin
                    w_pc_next = target_i;
                    w_retire  = 1'b1;
                end else begin
                    w_pc_next    = r_pc;
                    w_state_next = HALT;
                end
            end else begin
                w_pc_next = w_pc_plus;
                w_retire  = 1'b1;
            end
        end else if (r_state == MEM_WAIT && mem_done_i) begin
            w_pc_next    = w_pc_plus;
            w_retire     = 1'b1;
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= BOOT;
            r_pc    <= StartAddress;
        end else begin
            r_state <= w_state_next;
            if (r_state != HALT) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign pc_o      = r_pc;
    assign pc_plus_o = w_pc_plus;
    assign pc_next_o = w_pc_next;
    assign retire_o  = w_retire;
    assign stall_o   = (r_state == MEM_WAIT);
    assign halted_o  = (r_state == HALT);

`ifdef PC_CTRL_PERF_COUNTERS_EN
    logic [63:0] r_cycle;
    logic [63:0] r_instret;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_retire) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign cycle_o   = r_cycle;
    assign instret_o = r_instret;
`endif

endmodule
`default_nettype wire
